byte_deserializer: RTL and testbench

- Upstream feeder for the 8-bit Byte storage register.
- Collects a qualified serial bit stream into an 8-bit frame, with an optional parity bit per frame.
- On frame completion, presents the byte on data_out and pulses wrt for one clock, so the two connect directly: data_out -> data_in, wrt -> wrt.
- Single clock domain.

---
 rtl/byte_deserializer.sv | 82 ++++++++
 tb/tb_byte_deserializer.sv | 129 ++++++++++++
 2 files changed

// File: rtl/byte_deserializer.sv
// byte_deserializer: gathers qualified serial bits into bytes with optional parity check
// and emits each completed byte with a one-cycle wrt strobe.
module byte_deserializer #(
    parameter bit MSB_FIRST  = 1'b1,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sin,
    input  logic       sin_valid,
    input  logic       sync,
    output logic [7:0] data_out,
    output logic       wrt,
    output logic       par_err,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;
    state_t     state, state_n;
    logic [2:0] cnt, cnt_n;
    logic [7:0] sh, sh_n;
    logic       done, err_n;
    function automatic logic [7:0] place(input logic [7:0] s, input logic b);
        return MSB_FIRST ? {s[6:0], b} : {b, s[7:1]};
    endfunction
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sh_n    = sh;
        done    = 1'b0;
        err_n   = 1'b0;
        if (sync) begin
            state_n = sin_valid ? DATA : IDLE;
            cnt_n   = sin_valid ? 3'd1 : 3'd0;
            sh_n    = sin_valid ? place(8'h00, sin) : 8'h00;
        end else if (sin_valid) begin
            case (state)
                IDLE: begin
                    state_n = DATA;
                    cnt_n   = 3'd1;
                    sh_n    = place(8'h00, sin);
                end
                DATA: begin
                    sh_n  = place(sh, sin);
                    cnt_n = cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state_n = PARITY_EN ? PAR : IDLE;
                        done    = !PARITY_EN;
                    end
                end
                PAR: begin
                    // sh stays put here, so sh_n is the completed byte on every completing path
                    state_n = IDLE;
                    done    = 1'b1;
                    err_n   = ^sh ^ sin ^ PARITY_ODD;
                end
                default: state_n = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            sh       <= 8'h00;
            data_out <= 8'h00;
            wrt      <= 1'b0;
            par_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            sh    <= sh_n;
            wrt   <= done;
            busy  <= state_n != IDLE;
            if (done) begin
                data_out <= sh_n;
                par_err  <= err_n;
            end
        end
    end
endmodule

// File: tb/tb_byte_deserializer.sv
// tb_byte_deserializer: three parameter variants share one random/directed bit stream;
// a bit-queue model feeds per-instance scoreboards popped by a negedge monitor.
module tb_byte_deserializer;
    localparam logic [2:0] MSB = 3'b101;
    localparam logic [2:0] PEN = 3'b101;
    localparam logic [2:0] ODD = 3'b100;
    logic       clk = 1'b0, rst = 1'b0, sin = 1'b0, sin_valid = 1'b0, sync = 1'b0;
    logic [7:0] dout [3];
    logic       wrt_o [3], perr [3], busy_o [3];
    bit         bq [3][$];
    logic [8:0] sb [3][$];
    logic [7:0] hold_d [3];
    logic       hold_p [3], exp_busy [3];
    bit         run = 1'b0;
    int         checks = 0, errors = 0;

    always #5 clk = ~clk;

    byte_deserializer #(.MSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut0 (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .data_out(dout[0]), .wrt(wrt_o[0]), .par_err(perr[0]), .busy(busy_o[0]));
    byte_deserializer #(.MSB_FIRST(1'b0), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .data_out(dout[1]), .wrt(wrt_o[1]), .par_err(perr[1]), .busy(busy_o[1]));
    byte_deserializer #(.MSB_FIRST(1'b1), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (
        .clk(clk), .rst(rst), .sin(sin), .sin_valid(sin_valid), .sync(sync),
        .data_out(dout[2]), .wrt(wrt_o[2]), .par_err(perr[2]), .busy(busy_o[2]));

    task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst%0d got %0h want %0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Frame = first 8 accepted bits placed by arrival order, plus parity bit when enabled.
    task automatic model(input int k, input bit r, input bit s, input bit v, input bit y);
        logic [7:0] b;
        bit         x;
        int         need;
        need = PEN[k] ? 9 : 8;
        if (r) begin
            bq[k].delete();
            sb[k].delete();
            hold_d[k] = 8'h00;
            hold_p[k] = 1'b0;
        end else if (y) begin
            bq[k].delete();
            if (v) bq[k].push_back(s);
        end else if (v) begin
            bq[k].push_back(s);
            if (bq[k].size() == need) begin
                b = 8'h00;
                for (int i = 0; i < 8; i++) b[MSB[k] ? 7 - i : i] = bq[k][i];
                x = PEN[k] ? (^b ^ bq[k][8] ^ ODD[k]) : 1'b0;
                sb[k].push_back({x, b});
                hold_d[k] = b;
                hold_p[k] = x;
                bq[k].delete();
            end
        end
        exp_busy[k] = bq[k].size() > 0;
    endtask

    task automatic step(input bit r, input bit s, input bit v, input bit y);
        rst = r;
        sin = s;
        sin_valid = v;
        sync = y;
        @(posedge clk);
        for (int k = 0; k < 3; k++) model(k, r, s, v, y);
        @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input int par);
        for (int i = 7; i >= 0; i--) step(1'b0, b[i], 1'b1, 1'b0);
        if (par >= 0) step(1'b0, par[0], 1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (run) begin
            for (int k = 0; k < 3; k++) begin
                chk("wrt", k, {31'd0, wrt_o[k]}, {31'd0, sb[k].size() > 0});
                if (wrt_o[k] === 1'b1 && sb[k].size() > 0) begin
                    logic [8:0] e;
                    e = sb[k].pop_front();
                    chk("frame_data", k, {24'd0, dout[k]}, {24'd0, e[7:0]});
                    chk("frame_par", k, {31'd0, perr[k]}, {31'd0, e[8]});
                end
                chk("busy", k, {31'd0, busy_o[k]}, {31'd0, exp_busy[k]});
                chk("data_hold", k, {24'd0, dout[k]}, {24'd0, hold_d[k]});
                chk("par_hold", k, {31'd0, perr[k]}, {31'd0, hold_p[k]});
            end
        end
    end

    initial begin
        @(negedge clk);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        run = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'hA5, 0);
        send_byte(8'hA5, 1);
        send_byte(8'h3C, 0);
        for (int i = 0; i < 16; i++) step(1'b0, i == 0, i % 2 == 0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 1);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 299) == 0, 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        run = 1'b0;
        for (int k = 0; k < 3; k++) chk("sb_drained", k, sb[k].size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
